// File: rtl/battery_discharge_ctrl.sv
// Battery discharge controller: level countdown, power-state FSM, load gating.
// Define LOW_BATT_IRQ_EN to add the sticky low-battery interrupt (irq_clr/low_batt_irq).
module battery_discharge_ctrl #(
    parameter int FULL_LEVEL  = 100,
    parameter int SAVE_THRESH = 20,
    parameter int CRIT_THRESH = 5,
    parameter int WAKE_HYST   = 3,
    parameter int BASE_DIV    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_en,
    input  logic [1:0] load_level,
    input  logic       init_load,
    input  logic [7:0] init_level,
`ifdef LOW_BATT_IRQ_EN
    input  logic       irq_clr,
    output logic       low_batt_irq,
`endif
    output logic [7:0] battery_level,
    output logic [1:0] power_state,
    output logic       load_clk_en,
    output logic       throttle,
    output logic       shutdown
);

    localparam int PW = $clog2(BASE_DIV);

    localparam logic [7:0] FULL_L  = 8'(FULL_LEVEL);
    localparam logic [7:0] SAVE_L  = 8'(SAVE_THRESH);
    localparam logic [7:0] CRIT_L  = 8'(CRIT_THRESH);
    localparam logic [7:0] SAVE_UP = 8'(SAVE_THRESH + WAKE_HYST);
    localparam logic [7:0] CRIT_UP = 8'(CRIT_THRESH + WAKE_HYST);

    typedef enum logic [1:0] {
        OFF    = 2'b00,
        NORMAL = 2'b01,
        SAVE   = 2'b10,
        CRIT   = 2'b11
    } state_t;

    state_t        state;
    state_t        state_nxt;
    state_t        state_prev;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] period_m1;
    logic [1:0]    eff;
    logic [7:0]    init_sat;
    logic          counting;
    logic          dec_due;

    always_comb begin
        eff = 2'd0;
        unique case (state)
            NORMAL:  eff = load_level;
            SAVE:    eff = {1'b0, |load_level};
            default: eff = 2'd0;
        endcase
    end

    assign period_m1 = PW'((BASE_DIV >> eff) - 1);
    assign counting  = load_en && (state != OFF);
    assign dec_due   = counting && (prescaler >= period_m1)
                    && (battery_level != 8'd0);
    assign init_sat  = (init_level > FULL_L) ? FULL_L : init_level;

    // Downward moves are immediate; upward moves wait for the hysteresis bound.
    always_comb begin
        state_nxt = state;
        if (battery_level == 8'd0) begin
            state_nxt = OFF;
        end else begin
            unique case (state)
                OFF: begin
                    if (battery_level >= SAVE_UP)
                        state_nxt = NORMAL;
                    else if (battery_level >= CRIT_UP)
                        state_nxt = SAVE;
                end
                NORMAL: begin
                    if (battery_level <= CRIT_L)
                        state_nxt = CRIT;
                    else if (battery_level <= SAVE_L)
                        state_nxt = SAVE;
                end
                SAVE: begin
                    if (battery_level <= CRIT_L)
                        state_nxt = CRIT;
                    else if (battery_level >= SAVE_UP)
                        state_nxt = NORMAL;
                end
                CRIT: begin
                    if (battery_level >= SAVE_UP)
                        state_nxt = NORMAL;
                    else if (battery_level >= CRIT_UP)
                        state_nxt = SAVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= OFF;
            state_prev    <= OFF;
            battery_level <= 8'd0;
            prescaler     <= '0;
            load_clk_en   <= 1'b0;
            shutdown      <= 1'b0;
        end else begin
            state       <= state_nxt;
            state_prev  <= state;
            load_clk_en <= counting;
            shutdown    <= (state == OFF) && (state_prev != OFF);
            if (init_load)
                battery_level <= init_sat;
            else if (dec_due)
                battery_level <= battery_level - 8'd1;
            if (init_load || !counting || dec_due || (state_nxt != state))
                prescaler <= '0;
            else
                prescaler <= prescaler + PW'(1);
        end
    end

    assign power_state = state;
    assign throttle    = state[1];

`ifdef LOW_BATT_IRQ_EN
    logic irq_set;

    // Entering SAVE or CRIT (including SAVE -> CRIT) arms the interrupt.
    assign irq_set = state[1] && (state != state_prev);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            low_batt_irq <= 1'b0;
        else if (irq_set)
            low_batt_irq <= 1'b1;
        else if (irq_clr)
            low_batt_irq <= 1'b0;
    end
`endif

endmodule

// File: doc/battery_discharge_ctrl.md
Name: battery_discharge_ctrl

Overview:
Discharge-side counterpart to the fast charger. It owns the battery level while the device runs from battery and decrements it at a rate set by the load level. It classifies the battery into power states (OFF/NORMAL/POWER_SAVE/CRITICAL), throttles the load at low charge and gates the load clock enable. It issues a shutdown pulse when the battery reaches empty.

Parameters:
FULL_LEVEL, 100, maximum battery percentage; init_level saturates here
SAVE_THRESH, 20, level at or below which POWER_SAVE is entered
CRIT_THRESH, 5, level at or below which CRITICAL is entered
WAKE_HYST, 3, hysteresis added to a threshold for any upward state move
BASE_DIV, 8, cycles per 1% drop at load_level 0; must be a power of 2 and at least 8

Ports:
clk  in  1  system clock
reset  in  1  reset (see Behaviour)
load_en  in  1  device load active
load_level  in  2  requested load: 0 light, 1 medium, 2 heavy, 3 peak
init_load  in  1  single-cycle pulse: load battery_level from init_level
init_level  in  8  level handed over by the charger side
battery_level  out  8  current percentage
power_state  out  2  00 OFF, 01 NORMAL, 10 POWER_SAVE, 11 CRITICAL
load_clk_en  out  1  registered load clock enable
throttle  out  1  load forced down
shutdown  out  1  one-cycle pulse on entry to OFF

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. On reset: battery_level=0, power_state=OFF, prescaler=0, load_clk_en=0, shutdown=0.
- Effective load eff:
  - NORMAL: eff=load_level.
  - POWER_SAVE: eff=min(load_level,1).
  - CRITICAL: eff=0.
  - OFF: no discharge.
- Discharge period P=BASE_DIV>>eff: 8/4/2/1 cycles at the defaults.
- Prescaler behaviour:
  - Counts while load_en=1 and state!=OFF.
  - When prescaler>=P-1 and battery_level>0: battery_level decrements by 1 and the prescaler clears.
  - The >= comparison means a mid-count load change takes effect immediately.
  - Prescaler clears when load_en=0, on any power_state change, and on init_load.
  - battery_level never underflows; 0 holds.
- init_load: battery_level<=min(init_level,FULL_LEVEL). init_load has priority over a same-cycle decrement.
- State update: power_state is registered and evaluated every cycle from the registered battery_level, so state lags level by exactly one cycle. Direct multi-step jumps are allowed.
  - Downward, immediate:
    - level==0 -> OFF
    - else level<=CRIT_THRESH -> CRITICAL (if currently above)
    - else level<=SAVE_THRESH -> POWER_SAVE (if currently NORMAL)
  - Upward, only on the hysteresis bound:
    - CRITICAL -> POWER_SAVE needs level>=CRIT_THRESH+WAKE_HYST.
    - POWER_SAVE/CRITICAL -> NORMAL needs level>=SAVE_THRESH+WAKE_HYST.
    - OFF -> class needs level>CRIT_THRESH+WAKE_HYST-1, i.e. >=8. OFF then goes to the highest class satisfying the upward rules.
    - Otherwise the state holds.
- throttle: combinational, 1 in POWER_SAVE and CRITICAL.
- load_clk_en: registered, <=(state!=OFF)&&load_en, one cycle after the state or load_en change.
- shutdown: registered one-cycle pulse in the cycle after power_state becomes OFF from any non-OFF state. No pulse on reset.
- Reset mid-operation: immediate asynchronous clear of all state, including a pending shutdown.

Optional Feature:
LOW_BATT_IRQ_EN
- Defined:
  - Adds input irq_clr (1 bit) and output low_batt_irq (1 bit).
  - low_batt_irq is a sticky register, set the cycle after entry into POWER_SAVE or CRITICAL.
  - Cleared by irq_clr; set wins on a same-cycle collision.
  - Reset value 0.
- Undefined: neither port exists and no related logic is built.

Test Plan:
1. Reset, init_load init_level=100, load_en=1, load_level=3 -> level drops by 1 every cycle. Cycle after level=20: power_state=10 and throttle=1. Drops then occur every 4 cycles (eff=1).
2. NORMAL, level=50, load_level=0, load_en=1 -> level 49 after 8 cycles, 48 after 16. Dropping load_en for 3 cycles restarts the 8-cycle count.
3. POWER_SAVE, level drops to 5 -> CRITICAL next cycle; drops every 8 cycles. At level 0: OFF next cycle, shutdown high exactly 1 cycle, load_clk_en 0 one cycle after OFF.
4. POWER_SAVE at level 15: init_load 22 -> stays POWER_SAVE; init_load 23 -> NORMAL one cycle after the load.
5. OFF: init_load 7 -> stays OFF, load_clk_en=0. init_load 200 -> battery_level=100, NORMAL next cycle, load_clk_en=1 the cycle after.
6. Assert reset mid-discharge at level 37 -> battery_level=0, power_state=OFF, load_clk_en=0 without waiting for a clk edge. With LOW_BATT_IRQ_EN defined, low_batt_irq=0.
